// File: rtl/mem_port_arbiter_if.sv
// Client-side and memory-side signal bundle for mem_port_arbiter.
// The arbiter connects through the master modport; clients and memory model use slave.
interface mem_port_arbiter_if #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned AW       = 22,
  parameter int unsigned DW       = 32
);
  logic [NCLIENTS-1:0]    cl_req;
  logic [NCLIENTS-1:0]    cl_write;
  logic [NCLIENTS*AW-1:0] cl_addr;
  logic [NCLIENTS*DW-1:0] cl_wdata;
  logic [NCLIENTS-1:0]    cl_ack;
  logic [NCLIENTS-1:0]    cl_done;
  logic [DW-1:0]          cl_rdata;
  logic                   cl_err;

  logic                   mem_req;
  logic                   mem_write;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ready;
  logic                   mem_done;
  logic [DW-1:0]          mem_rdata;

  logic [2:0]             grant;
  logic                   busy;

  modport master (
    input  cl_req, cl_write, cl_addr, cl_wdata, mem_ready, mem_done, mem_rdata,
    output cl_ack, cl_done, cl_rdata, cl_err, mem_req, mem_write, mem_addr, mem_wdata,
    output grant, busy
  );

  modport slave (
    output cl_req, cl_write, cl_addr, cl_wdata, mem_ready, mem_done, mem_rdata,
    input  cl_ack, cl_done, cl_rdata, cl_err, mem_req, mem_write, mem_addr, mem_wdata,
    input  grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin N-client arbiter onto one request/ready/done memory port with completion timeout.
// Build macro ARB_PRIO0_EN gives client 0 fixed top priority over the round-robin group.
module mem_port_arbiter #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned AW       = 22,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned     CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [2:0]      idx_q, idx_d;
  logic [2:0]      last_q, last_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NCLIENTS-1:0] rr_req;
  logic                rr_hi_valid, rr_lo_valid;
  logic [2:0]          rr_hi_idx, rr_lo_idx;
  logic                pick_valid;
  logic [2:0]          pick_idx;
  logic                sel_write;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;

  logic                ack_fire, done_ok, timeout_hit, done_fire;
  logic [DW-1:0]       rdata_out;
  logic [NCLIENTS-1:0] grant_oh;

  // Round-robin: first requester above last_q wins, otherwise first at or below it.
  always_comb begin
    rr_req = bus.cl_req;
`ifdef ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    rr_hi_valid = 1'b0;
    rr_lo_valid = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    for (int i = 0; i < int'(NCLIENTS); i++) begin
      if (rr_req[i]) begin
        if (i > int'(last_q)) begin
          if (!rr_hi_valid) begin
            rr_hi_valid = 1'b1;
            rr_hi_idx   = 3'(i);
          end
        end else if (!rr_lo_valid) begin
          rr_lo_valid = 1'b1;
          rr_lo_idx   = 3'(i);
        end
      end
    end
    pick_valid = rr_hi_valid | rr_lo_valid;
    pick_idx   = rr_hi_valid ? rr_hi_idx : rr_lo_idx;
`ifdef ARB_PRIO0_EN
    if (bus.cl_req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NCLIENTS); i++) begin
      if (pick_idx == 3'(i)) begin
        sel_write = bus.cl_write[i];
        sel_addr  = bus.cl_addr[i*AW +: AW];
        sel_wdata = bus.cl_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ack_fire    = (state_q == StIssue) && bus.mem_ready;
    done_ok     = bus.mem_done && ((state_q == StWait) || ack_fire);
    timeout_hit = (TIMEOUT > 0) && (state_q == StWait) && !bus.mem_done && (cnt_q == CntLast);
    done_fire   = done_ok || timeout_hit;
    if (timeout_hit) begin
      rdata_out = '1;
    end else if (done_ok && !write_q) begin
      rdata_out = bus.mem_rdata;
    end else begin
      rdata_out = rdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: if (ack_fire) state_d = done_ok ? StIdle : StWait;
      StWait:  if (done_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(NCLIENTS); i++) begin
      grant_oh[i] = (idx_q == 3'(i));
    end
    bus.mem_req   = (state_q == StIssue);
    bus.mem_write = write_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cl_ack    = ack_fire ? grant_oh : '0;
    bus.cl_done   = done_fire ? grant_oh : '0;
    bus.cl_err    = timeout_hit;
    bus.cl_rdata  = rdata_out;
    bus.grant     = idx_q;
    bus.busy      = (state_q != StIdle);
  end

  always_comb begin
    idx_d   = idx_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_out;
    if ((state_q == StIdle) && pick_valid) begin
      idx_d   = pick_idx;
      write_d = sel_write;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
    end
    if (ack_fire) begin
`ifdef ARB_PRIO0_EN
      if (idx_q != '0) last_d = idx_q;
`else
      last_d = idx_q;
`endif
    end
    // Held at zero through ISSUE so WAIT always starts from a clean count; saturates.
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      last_q  <= 3'(NCLIENTS - 1);
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
